// File: rtl/alarm_controller_pkg.sv
// Shared types and BCD constants for the alarm stage.
// Also holds the alarm-time legality check used on the set port.
package alarm_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_00 = 8'h00;

  // Hours 01..12 and minutes 00..59, every nibble a legal BCD digit.
  function automatic logic bcd_time_ok(input logic [7:0] hh, input logic [7:0] mm);
    logic hh_ok;
    logic mm_ok;
    hh_ok = ((hh[7:4] == 4'd0) && (hh[3:0] >= 4'd1) && (hh[3:0] <= 4'd9)) ||
            ((hh[7:4] == 4'd1) && (hh[3:0] <= 4'd2));
    mm_ok = (mm[7:4] <= 4'd5) && (mm[3:0] <= 4'd9);
    return hh_ok && mm_ok;
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Alarm-time load port. A transfer happens on a clock edge where set_valid && set_ready;
// the offer fields must be stable while set_valid is high, and set_err answers a rejected transfer one edge later.
interface alarm_controller_if;
  logic       set_valid;
  logic       set_ready;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic       set_pm;
  logic       set_err;

  modport master (
    output set_valid, set_hh, set_mm, set_pm,
    input  set_ready, set_err
  );

  modport slave (
    input  set_valid, set_hh, set_mm, set_pm,
    output set_ready, set_err
  );
endinterface

// File: rtl/alarm_controller_bcd_time_add.sv
// Combinational add of 0..59 minutes to a 12-hour BCD time.
// Carries into the hour with 11->12 toggling AM/PM and 12->01 keeping it.
module bcd_time_add
  import alarm_controller_pkg::*;
(
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic       pm,
  input  logic [5:0] add_min,
  output logic [7:0] sum_hh,
  output logic [7:0] sum_mm,
  output logic       sum_pm
);

  logic [7:0] total;
  logic [7:0] mins;
  logic       carry;

  always_comb begin
    total  = (8'(mm[7:4]) * 8'd10) + 8'(mm[3:0]) + 8'(add_min);
    carry  = (total >= 8'd60);
    mins   = carry ? (total - 8'd60) : total;
    sum_mm = {4'(mins / 8'd10), 4'(mins % 8'd10)};

    sum_hh = hh;
    sum_pm = pm;
    if (carry) begin
      if (hh == BCD_11) begin
        sum_hh = BCD_12;
        sum_pm = ~pm;
      end else if (hh == BCD_12) begin
        sum_hh = 8'h01;
      end else if (hh[3:0] == 4'd9) begin
        sum_hh = {hh[7:4] + 4'd1, 4'd0};
      end else begin
        sum_hh = hh + 8'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Programmable alarm: holds an alarm time, rings on the rising edge of a time match,
// and handles stop, snooze re-ring and ring timeout.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [7:0]          cur_hh,
  input  logic [7:0]          cur_mm,
  input  logic [7:0]          cur_ss,
  input  logic                cur_pm,
  input  logic                arm,
  alarm_controller_if.slave   set_port,
  input  logic                stop,
  input  logic                snooze,
  output logic                ring,
  output logic                snoozing,
  output logic                missed,
  output logic [7:0]          alarm_hh,
  output logic [7:0]          alarm_mm,
  output logic                alarm_pm,
  output state_t              state_dbg
);

  localparam int CW = $clog2(RING_SECS + 1);
  localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] ring_cnt;
  logic [7:0]    snz_hh;
  logic [7:0]    snz_mm;
  logic          snz_pm;
  logic [7:0]    add_hh;
  logic [7:0]    add_mm;
  logic          add_pm;
  logic [7:0]    t_hh;
  logic [7:0]    t_mm;
  logic          t_pm;
  logic          m;
  logic          m_q;
  logic          evt;
  logic          set_fire;
  logic          set_ok;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          snz_load;
  logic          missed_nxt;

  bcd_time_add u_snooze_add (
    .hh      (cur_hh),
    .mm      (cur_mm),
    .pm      (cur_pm),
    .add_min (6'(SNOOZE_MIN)),
    .sum_hh  (add_hh),
    .sum_mm  (add_mm),
    .sum_pm  (add_pm)
  );

  assign set_port.set_ready = (state == IDLE);
  assign set_fire  = set_port.set_valid && set_port.set_ready;
  assign set_ok    = bcd_time_ok(set_port.set_hh, set_port.set_mm);
  assign state_dbg = state;

  // The match target follows the snooze time only while snoozing.
  always_comb begin
    t_hh = alarm_hh;
    t_mm = alarm_mm;
    t_pm = alarm_pm;
    if (state == SNOOZE) begin
      t_hh = snz_hh;
      t_mm = snz_mm;
      t_pm = snz_pm;
    end
    m   = (cur_ss == BCD_00) && (cur_hh == t_hh) && (cur_mm == t_mm) && (cur_pm == t_pm);
    evt = m && !m_q;
  end

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    snz_load   = 1'b0;
    missed_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (arm && evt) begin
          next_state = RINGING;
          cnt_clr    = 1'b1;
        end
      end
      RINGING: begin
        if (!arm || stop) begin
          next_state = IDLE;
        end else if (snooze) begin
          next_state = SNOOZE;
          snz_load   = 1'b1;
        end else if (tick && (ring_cnt == RING_LAST)) begin
          next_state = IDLE;
          missed_nxt = 1'b1;
        end else if (tick) begin
          cnt_inc = 1'b1;
        end
      end
      SNOOZE: begin
        if (!arm || stop) begin
          next_state = IDLE;
        end else if (evt) begin
          next_state = RINGING;
          cnt_clr    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      ring             <= 1'b0;
      snoozing         <= 1'b0;
      missed           <= 1'b0;
      set_port.set_err <= 1'b0;
      ring_cnt         <= '0;
      m_q              <= 1'b0;
      alarm_hh         <= BCD_12;
      alarm_mm         <= BCD_00;
      alarm_pm         <= 1'b0;
      snz_hh           <= BCD_12;
      snz_mm           <= BCD_00;
      snz_pm           <= 1'b0;
    end else begin
      state            <= next_state;
      ring             <= (next_state == RINGING);
      snoozing         <= (next_state == SNOOZE);
      missed           <= missed_nxt;
      set_port.set_err <= set_fire && !set_ok;
      m_q              <= m;
      if (cnt_clr) begin
        ring_cnt <= '0;
      end else if (cnt_inc) begin
        ring_cnt <= ring_cnt + CW'(1);
      end
      if (set_fire && set_ok) begin
        alarm_hh <= set_port.set_hh;
        alarm_mm <= set_port.set_mm;
        alarm_pm <= set_port.set_pm;
      end
      if (snz_load) begin
        snz_hh <= add_hh;
        snz_mm <= add_mm;
        snz_pm <= add_pm;
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: the driver pushes hand-computed output snapshots,
// and a negedge monitor pops and compares them against the DUT.
module tb_alarm_controller;
  import alarm_controller_pkg::*;

  localparam int W = 22;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [7:0] cur_hh, cur_mm, cur_ss;
  logic       cur_pm;
  logic       arm, stop, snooze;
  logic       ring, snoozing, missed;
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_pm;
  state_t     state_dbg;

  alarm_controller_if set_if ();

  alarm_controller #(.RING_SECS(3), .SNOOZE_MIN(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .cur_hh    (cur_hh),
    .cur_mm    (cur_mm),
    .cur_ss    (cur_ss),
    .cur_pm    (cur_pm),
    .arm       (arm),
    .set_port  (set_if.slave),
    .stop      (stop),
    .snooze    (snooze),
    .ring      (ring),
    .snoozing  (snoozing),
    .missed    (missed),
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_pm  (alarm_pm),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [7:0]   exp_hh = 8'h12;
  logic [7:0]   exp_mm = 8'h00;
  logic         exp_pm = 1'b0;

  wire [W-1:0] obs = {ring, snoozing, missed, set_if.set_err, set_if.set_ready,
                      alarm_pm, alarm_hh, alarm_mm};

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (obs === e) n_pass++;
      else $display("FAIL %s: got ring/snz/missed/err/ready=%b%b%b%b%b alarm=%h:%h pm=%b, expected %b%b%b%b%b alarm=%h:%h pm=%b",
                    nm, obs[21], obs[20], obs[19], obs[18], obs[17], obs[15:8], obs[7:0], obs[16],
                    e[21], e[20], e[19], e[18], e[17], e[15:8], e[7:0], e[16]);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss, input logic pm);
    cur_hh = hh; cur_mm = mm; cur_ss = ss; cur_pm = pm;
  endtask

  task automatic offer(input logic v, input logic [7:0] hh, input logic [7:0] mm, input logic pm);
    set_if.set_valid = v; set_if.set_hh = hh; set_if.set_mm = mm; set_if.set_pm = pm;
  endtask

  task automatic expect_out(input string name, input logic r, input logic s, input logic m,
                            input logic e, input logic rdy);
    exp_q.push_back({r, s, m, e, rdy, exp_pm, exp_hh, exp_mm});
    name_q.push_back(name);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; arm = 1'b0; stop = 1'b0; snooze = 1'b0;
    set_time(8'h01, 8'h00, 8'h00, 1'b0);
    offer(1'b0, 8'h00, 8'h00, 1'b0);
    step(2);
    expect_out("reset", 0, 0, 0, 0, 1);

    // load 06:30 AM and ring on the rising match
    reset = 1'b0;
    offer(1'b1, 8'h06, 8'h30, 1'b0);
    step(1);
    offer(1'b0, 8'h06, 8'h30, 1'b0);
    exp_hh = 8'h06; exp_mm = 8'h30; exp_pm = 1'b0;
    expect_out("set_0630", 0, 0, 0, 0, 1);
    arm = 1'b1;
    set_time(8'h06, 8'h29, 8'h59, 1'b0);
    step(1);
    expect_out("pre_match", 0, 0, 0, 0, 1);
    set_time(8'h06, 8'h30, 8'h00, 1'b0);
    step(1);
    expect_out("ring_on", 1, 0, 0, 0, 0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    expect_out("stop", 0, 0, 0, 0, 1);
    step(2);
    expect_out("hold_no_event", 0, 0, 0, 0, 1);

    // illegal offers are refused with a single set_err pulse
    set_time(8'h01, 8'h00, 8'h00, 1'b0);
    offer(1'b1, 8'h13, 8'h00, 1'b0);
    step(1);
    offer(1'b0, 8'h13, 8'h00, 1'b0);
    expect_out("err_hh", 0, 0, 0, 1, 1);
    step(1);
    expect_out("err_pulse_end", 0, 0, 0, 0, 1);
    offer(1'b1, 8'h05, 8'h5A, 1'b1);
    step(1);
    offer(1'b0, 8'h05, 8'h5A, 1'b1);
    expect_out("err_mm", 0, 0, 0, 1, 1);

    // an offer held during RINGING waits for IDLE
    set_time(8'h06, 8'h30, 8'h00, 1'b0);
    step(1);
    expect_out("ring2", 1, 0, 0, 0, 0);
    offer(1'b1, 8'h08, 8'h15, 1'b1);
    step(2);
    expect_out("set_blocked", 1, 0, 0, 0, 0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    expect_out("stop2", 0, 0, 0, 0, 1);
    step(1);
    offer(1'b0, 8'h08, 8'h15, 1'b1);
    exp_hh = 8'h08; exp_mm = 8'h15; exp_pm = 1'b1;
    expect_out("set_after_idle", 0, 0, 0, 0, 1);

    // snooze from 11:55 AM targets 12:04 PM
    set_time(8'h01, 8'h00, 8'h00, 1'b0);
    offer(1'b1, 8'h11, 8'h55, 1'b0);
    step(1);
    offer(1'b0, 8'h11, 8'h55, 1'b0);
    exp_hh = 8'h11; exp_mm = 8'h55; exp_pm = 1'b0;
    expect_out("set_1155", 0, 0, 0, 0, 1);
    set_time(8'h11, 8'h55, 8'h00, 1'b0);
    step(1);
    expect_out("ring_1155", 1, 0, 0, 0, 0);
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    expect_out("snoozed", 0, 1, 0, 0, 0);
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    expect_out("snooze_ignored", 0, 1, 0, 0, 0);
    set_time(8'h12, 8'h04, 8'h00, 1'b0);
    step(2);
    expect_out("am_no_trigger", 0, 1, 0, 0, 0);
    set_time(8'h12, 8'h03, 8'h59, 1'b1);
    step(1);
    set_time(8'h12, 8'h04, 8'h00, 1'b1);
    step(1);
    expect_out("snooze_ring", 1, 0, 0, 0, 0);

    // three ticks with no response time the ring out
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
    expect_out("ring_after_2", 1, 0, 0, 0, 0);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    expect_out("missed", 0, 0, 1, 0, 1);
    step(1);
    expect_out("missed_end", 0, 0, 0, 0, 1);

    // stop wins over a simultaneous snooze
    set_time(8'h11, 8'h55, 8'h00, 1'b0);
    step(1);
    expect_out("ring3", 1, 0, 0, 0, 0);
    stop = 1'b1; snooze = 1'b1;
    step(1);
    stop = 1'b0; snooze = 1'b0;
    expect_out("stop_snooze", 0, 0, 0, 0, 1);

    // disarming in SNOOZE returns to IDLE
    set_time(8'h01, 8'h00, 8'h00, 1'b0);
    step(1);
    set_time(8'h11, 8'h55, 8'h00, 1'b0);
    step(1);
    expect_out("ring4", 1, 0, 0, 0, 0);
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    expect_out("snoozed2", 0, 1, 0, 0, 0);
    arm = 1'b0;
    step(1);
    expect_out("disarm_snooze", 0, 0, 0, 0, 1);
    arm = 1'b1;

    // reset mid-ring restores 12:00 AM, which then rings
    set_time(8'h01, 8'h00, 8'h00, 1'b0);
    step(1);
    set_time(8'h11, 8'h55, 8'h00, 1'b0);
    step(1);
    expect_out("ring5", 1, 0, 0, 0, 0);
    reset = 1'b1;
    step(1);
    exp_hh = 8'h12; exp_mm = 8'h00; exp_pm = 1'b0;
    expect_out("reset_ring", 0, 0, 0, 0, 1);
    reset = 1'b0;
    set_time(8'h12, 8'h00, 8'h00, 1'b0);
    step(1);
    expect_out("ring_midnight", 1, 0, 0, 0, 0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    expect_out("stop_midnight", 0, 0, 0, 0, 1);

    // re-arming while the match second is still held gives no event
    arm = 1'b0;
    step(1);
    arm = 1'b1;
    step(2);
    expect_out("arm_in_match", 0, 0, 0, 0, 1);

    step(2);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d unchecked expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
